block_memory_responder: RTL and testbench

- Memory-side responder for the 128-bit block / 28-bit block-address cache refill protocol used by the instruction and data caches.
- Accepts one READ or WRITE of a full 16-byte block.
- Holds BUSYWAIT high for a parameterised access latency, then performs the access and releases BUSYWAIT for exactly one cycle.
- Sits below a cache and is a drop-in main-memory model / controller for both cache ports.

---
 rtl/block_memory_responder_pkg.sv | 37 +++
 rtl/block_memory_responder_if.sv | 25 ++
 rtl/block_mem_array.sv | 36 +++
 rtl/block_memory_responder.sv | 111 +++++++++++
 tb/tb_block_memory_responder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_memory_responder_pkg.sv
// Shared widths, FSM encoding and request types for the block memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package block_memory_responder_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = BLOCK_BYTES * 8;
    localparam int BADDR_W     = 28;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [BADDR_W-1:0] baddr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef struct packed {
        op_t    op;
        block_t dat;
    } req_t;

    // Resolves a simultaneous READ+WRITE according to the configured priority.
    function automatic op_t pick_op(input logic rd, input logic wr, input bit write_priority);
        if (rd && wr) begin
            return write_priority ? OP_WRITE : OP_READ;
        end
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/block_memory_responder_if.sv
// Cache-side block refill bus: one outstanding READ or WRITE of a 128-bit block.
// Latency: n/a (wiring only).
// Backpressure: BUSYWAIT stalls the requester, which holds READ/WRITE until it falls.
interface block_memory_responder_if;
    import block_memory_responder_pkg::*;

    logic   READ;
    logic   WRITE;
    baddr_t ADDRESS;
    block_t WRITEDATA;
    block_t READDATA;
    logic   BUSYWAIT;
    logic   CONFLICT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT, CONFLICT
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT, CONFLICT
    );

endinterface

// File: rtl/block_mem_array.sv
// Single-port DEPTH x 128-bit block storage with write enable and registered read.
// Latency: write and read both complete at the enabled edge.
// Backpressure: none; accepts an access every cycle.
module block_mem_array
    import block_memory_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  block_t           wdat,
    output block_t           rdat
);

    block_t mem [DEPTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat <= '0;
        end else if (re) begin
            rdat <= mem[idx];
        end
    end

endmodule

// File: rtl/block_memory_responder.sv
// Main-memory responder for cache block refills: latches one request, waits, then accesses storage.
// Latency: access at LATENCY edges after acceptance; BUSYWAIT low for the one following cycle.
// Backpressure: BUSYWAIT is high from the request cycle until the access completes.
module block_memory_responder
    import block_memory_responder_pkg::*;
#(
    parameter int DEPTH_BLOCKS   = 256,
    parameter int LATENCY        = 5,
    parameter bit WRITE_PRIORITY = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    block_memory_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH_BLOCKS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             conflict_q, conflict_d;
    logic             mem_we;
    logic             mem_re;
    logic             busywait;
    block_t           rdat;

    // Blocks alias modulo DEPTH_BLOCKS; the upper address bits are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ADDRESS[BADDR_W-1:IDX_W];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            idx_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            idx_q      <= idx_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        idx_d      = idx_q;
        conflict_d = conflict_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        busywait   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Combinational stall so the requester waits in its own request cycle.
                busywait = bus.READ | bus.WRITE;
                if (bus.READ || bus.WRITE) begin
                    req_d.op  = pick_op(bus.READ, bus.WRITE, WRITE_PRIORITY);
                    req_d.dat = bus.WRITEDATA;
                    idx_d     = bus.ADDRESS[IDX_W-1:0];
                    cnt_d     = CNT_LAST;
                    state_d   = ST_BUSY;
                    if (bus.READ && bus.WRITE) begin
                        conflict_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                busywait = 1'b1;
                if (cnt_q == '0) begin
                    mem_we  = (req_q.op == OP_WRITE);
                    mem_re  = (req_q.op == OP_READ);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    block_mem_array #(
        .DEPTH (DEPTH_BLOCKS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (CLK),
        .rst_n (RESET),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (idx_q),
        .wdat  (req_q.dat),
        .rdat  (rdat)
    );

    assign bus.READDATA = rdat;
    assign bus.BUSYWAIT = busywait;
    assign bus.CONFLICT = conflict_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: two instances (slow write-priority, fast read-priority)
// driven by directed and randomized block transactions against a reference memory model.
module tb_block_memory_responder;
    import block_memory_responder_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n    [2];
    logic   req_rd   [2];
    logic   req_wr   [2];
    baddr_t req_addr [2];
    block_t req_wdat [2];
    block_t rdat     [2];
    logic   busy     [2];
    logic   conf     [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected storage, last read block and sticky conflict flag per instance.
    block_t model_mem [int];
    block_t exp_rd    [2];
    logic   exp_conf  [2];

    always #5 clk = ~clk;

    block_memory_responder_if bus_a ();
    block_memory_responder_if bus_b ();

    assign bus_a.READ      = req_rd[0];
    assign bus_a.WRITE     = req_wr[0];
    assign bus_a.ADDRESS   = req_addr[0];
    assign bus_a.WRITEDATA = req_wdat[0];
    assign rdat[0]         = bus_a.READDATA;
    assign busy[0]         = bus_a.BUSYWAIT;
    assign conf[0]         = bus_a.CONFLICT;

    assign bus_b.READ      = req_rd[1];
    assign bus_b.WRITE     = req_wr[1];
    assign bus_b.ADDRESS   = req_addr[1];
    assign bus_b.WRITEDATA = req_wdat[1];
    assign rdat[1]         = bus_b.READDATA;
    assign busy[1]         = bus_b.BUSYWAIT;
    assign conf[1]         = bus_b.CONFLICT;

    block_memory_responder #(
        .DEPTH_BLOCKS   (256),
        .LATENCY        (5),
        .WRITE_PRIORITY (1'b1)
    ) dut_a (
        .CLK   (clk),
        .RESET (rst_n[0]),
        .bus   (bus_a)
    );

    block_memory_responder #(
        .DEPTH_BLOCKS   (16),
        .LATENCY        (1),
        .WRITE_PRIORITY (1'b0)
    ) dut_b (
        .CLK   (clk),
        .RESET (rst_n[1]),
        .bus   (bus_b)
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 5 : 1;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    function automatic bit wp_of(input int d);
        return (d == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic int key_of(input int d, input baddr_t addr);
        return d * 65536 + int'(addr % 28'(depth_of(d)));
    endfunction

    // Starts just after a rising edge; ends just after a rising edge with the request dropped.
    task automatic do_txn(input int d, input logic rd, input logic wr, input baddr_t addr,
                          input block_t dat, input string name);
        int cycles;
        int key;
        bit exec_wr;
        req_rd[d]   = rd;
        req_wr[d]   = wr;
        req_addr[d] = addr;
        req_wdat[d] = dat;
        @(negedge clk);
        n_checks++;
        if (busy[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_cycle_busywait: got %b expected 1", name, busy[d]);
        end
        cycles = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end while (busy[d] === 1'b1 && cycles < 64);

        key     = key_of(d, addr);
        exec_wr = wr && (!rd || wp_of(d));
        if (rd && wr) exp_conf[d] = 1'b1;
        if (exec_wr) model_mem[key] = dat;
        else if (model_mem.exists(key)) exp_rd[d] = model_mem[key];

        n_checks++;
        if (cycles != lat_of(d) + 1) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, lat_of(d) + 1);
        end
        n_checks++;
        if (rdat[d] !== exp_rd[d]) begin
            n_fail++;
            $display("FAIL %s readdata_done: got %h expected %h", name, rdat[d], exp_rd[d]);
        end
        n_checks++;
        if (conf[d] !== exp_conf[d]) begin
            n_fail++;
            $display("FAIL %s conflict: got %b expected %b", name, conf[d], exp_conf[d]);
        end
        @(posedge clk);
        #1;
        req_rd[d] = 1'b0;
        req_wr[d] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy[d] !== 1'b0 || rdat[d] !== exp_rd[d]) begin
            n_fail++;
            $display("FAIL %s idle_hold: got busy=%b data=%h expected busy=0 data=%h",
                     name, busy[d], rdat[d], exp_rd[d]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (busy[d] !== 1'b0 || rdat[d] !== '0 || conf[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got busy=%b data=%h conflict=%b expected 0/0/0",
                         d, busy[d], rdat[d], conf[d]);
            end
            exp_rd[d]   = '0;
            exp_conf[d] = 1'b0;
        end
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b0, 1'b1, 28'h0000003, 128'h0123456789ABCDEF_FEDCBA9876543210, "write_03");
        do_txn(0, 1'b1, 1'b0, 28'h0000003, '0, "read_03");
    endtask

    task automatic test_alias();
        do_txn(0, 1'b0, 1'b1, 28'h0000105, '1, "write_alias_105");
        do_txn(0, 1'b1, 1'b0, 28'h0000005, '0, "read_alias_005");
    endtask

    task automatic test_conflict();
        do_txn(0, 1'b1, 1'b1, 28'h0000010, {16{8'hAA}}, "conflict_wr_prio");
        do_txn(0, 1'b1, 1'b0, 28'h0000010, '0, "read_after_conflict");
    endtask

    task automatic test_reset_abort();
        block_t prior;
        prior = {$urandom, $urandom, $urandom, $urandom};
        do_txn(0, 1'b0, 1'b1, 28'h0000020, prior, "write_20_prior");
        req_wr[0]   = 1'b1;
        req_addr[0] = 28'h0000020;
        req_wdat[0] = {16{8'h55}};
        repeat (3) @(posedge clk);
        #1;
        rst_n[0]  = 1'b0;
        req_wr[0] = 1'b0;
        #1;
        exp_rd[0]   = '0;
        exp_conf[0] = 1'b0;
        n_checks++;
        if (busy[0] !== 1'b0 || rdat[0] !== '0 || conf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset_outputs: got busy=%b data=%h conflict=%b expected 0/0/0",
                     busy[0], rdat[0], conf[0]);
        end
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, 1'b1, 1'b0, 28'h0000020, '0, "read_20_after_abort");
    endtask

    task automatic test_back_to_back();
        block_t exp;
        do_txn(1, 1'b0, 1'b1, 28'h0000001, {$urandom, $urandom, $urandom, $urandom}, "b2b_fill");
        exp         = model_mem[key_of(1, 28'h0000001)];
        exp_rd[1]   = exp;
        req_rd[1]   = 1'b1;
        req_addr[1] = 28'h0000001;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy[1] !== (i % 3 != 2)) begin
                n_fail++;
                $display("FAIL b2b_busywait[%0d]: got %b expected %b", i, busy[1], (i % 3 != 2));
            end
            if (i % 3 == 2) begin
                n_checks++;
                if (rdat[1] !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_readdata[%0d]: got %h expected %h", i, rdat[1], exp);
                end
            end
        end
        @(posedge clk);
        #1;
        req_rd[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release: got %b expected 0", busy[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int d, input int n);
        for (int t = 0; t < n; t++) begin
            int     k;
            int     sel;
            logic   rd;
            logic   wr;
            baddr_t upper;
            baddr_t addr;
            k     = $urandom_range(0, 7);
            upper = 28'($urandom);
            addr  = upper - (upper % 28'(depth_of(d))) + 28'(k);
            sel   = $urandom_range(0, 3);
            rd    = (sel != 1);
            wr    = (sel == 1 || sel == 2);
            if (!(wr && (!rd || wp_of(d))) && !model_mem.exists(key_of(d, addr))) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            do_txn(d, rd, wr, addr, {$urandom, $urandom, $urandom, $urandom}, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]    = 1'b0;
            req_rd[d]   = 1'b0;
            req_wr[d]   = 1'b0;
            req_addr[d] = '0;
            req_wdat[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        test_write_read();
        test_alias();
        test_conflict();
        test_reset_abort();
        test_back_to_back();
        test_random(0, 15);
        test_random(1, 25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
